// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a multi-cycle ALU: arbitrates one
// command at a time, drives the ALU, and returns the result with timeout/illegal-op status.
module alu_arbiter #(
  parameter int unsigned MAX_WAIT = 15,
  parameter logic [4:0]  OP_MAX   = 5'b00100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_dtype,
  input  logic [4:0]  req0_op,
  input  logic [15:0] req0_src1,
  input  logic [15:0] req0_src2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_dtype,
  input  logic [4:0]  req1_op,
  input  logic [15:0] req1_src1,
  input  logic [15:0] req1_src2,
  output logic [3:0]  alu_dtype,
  output logic [4:0]  alu_operator,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  output logic        alu_start,
  input  logic [31:0] alu_calc_res,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err
);

  // state | meaning
  // IDLE  | waiting for a request; grants one and captures its command
  // EXEC  | command issued to ALU, waiting for alu_done or timeout
  // RESP  | response held on rsp_* until the consumer accepts it
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OP  = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  dtype_q, dtype_d;
  logic [4:0]  op_q, op_d;
  logic [15:0] src1_q, src1_d;
  logic [15:0] src2_q, src2_d;
  logic        id_q, id_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  err_q, err_d;

  logic        gnt_any;
  logic        gnt_id;
  logic [3:0]  sel_dtype;
  logic [4:0]  sel_op;
  logic [15:0] sel_src1;
  logic [15:0] sel_src2;

  // On a tie the requester that lost last time wins; a lone requester always wins.
  always_comb begin
    gnt_any   = req0_valid || req1_valid;
    gnt_id    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    sel_dtype = gnt_id ? req1_dtype : req0_dtype;
    sel_op    = gnt_id ? req1_op    : req0_op;
    sel_src1  = gnt_id ? req1_src1  : req0_src1;
    sel_src2  = gnt_id ? req1_src2  : req0_src2;
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    last_grant_d = last_grant_q;
    dtype_d      = dtype_q;
    op_d         = op_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    id_d         = id_q;
    data_d       = data_q;
    err_d        = err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          req0_ready   = !rst && !gnt_id;
          req1_ready   = !rst && gnt_id;
          last_grant_d = gnt_id;
          id_d         = gnt_id;
          dtype_d      = sel_dtype;
          op_d         = sel_op;
          src1_d       = sel_src1;
          src2_d       = sel_src2;
          wait_cnt_d   = 8'd0;
          if (sel_op > OP_MAX) begin
            data_d  = 32'd0;
            err_d   = ERR_OP;
            state_d = S_RESP;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        // alu_done takes priority over a timeout landing in the same cycle
        if (alu_done) begin
          data_d  = alu_calc_res;
          err_d   = ERR_OK;
          state_d = S_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          data_d  = 32'd0;
          err_d   = ERR_TMO;
          state_d = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 8'd0;
      last_grant_q <= 1'b1;
      dtype_q      <= 4'd0;
      op_q         <= 5'd0;
      src1_q       <= 16'd0;
      src2_q       <= 16'd0;
      id_q         <= 1'b0;
      data_q       <= 32'd0;
      err_q        <= ERR_OK;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      last_grant_q <= last_grant_d;
      dtype_q      <= dtype_d;
      op_q         <= op_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      id_q         <= id_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  assign alu_start    = (state_q == S_EXEC);
  assign rsp_valid    = (state_q == S_RESP);
  assign alu_dtype    = dtype_q;
  assign alu_operator = op_q;
  assign alu_src1     = src1_q;
  assign alu_src2     = src2_q;
  assign rsp_id       = id_q;
  assign rsp_data     = data_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: arbitration, latency, illegal op,
// timeout boundary, response backpressure and mid-command reset.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_dtype, req1_dtype;
  logic [4:0]  req0_op, req1_op;
  logic [15:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [3:0]  alu_dtype;
  logic [4:0]  alu_operator;
  logic [15:0] alu_src1, alu_src2;
  logic        alu_start;
  logic [31:0] alu_calc_res;
  logic        alu_done;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  int checks = 0;
  int failures = 0;
  int start_cnt;

  alu_arbiter #(.MAX_WAIT(15), .OP_MAX(5'b00100)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dtype(req0_dtype),
    .req0_op(req0_op), .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dtype(req1_dtype),
    .req1_op(req1_op), .req1_src1(req1_src1), .req1_src2(req1_src2),
    .alu_dtype(alu_dtype), .alu_operator(alu_operator), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .alu_start(alu_start), .alu_calc_res(alu_calc_res),
    .alu_done(alu_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_alu_start"}, 32'(alu_start), 32'd0);
    chk({tag, "_alu_dtype"}, 32'(alu_dtype), 32'd0);
    chk({tag, "_alu_operator"}, 32'(alu_operator), 32'd0);
    chk({tag, "_alu_src1"}, 32'(alu_src1), 32'd0);
    chk({tag, "_alu_src2"}, 32'(alu_src2), 32'd0);
    chk({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
    chk({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_dtype = 4'd1; req0_op = 5'd0; req0_src1 = 16'h0003; req0_src2 = 16'h0004;
    req1_dtype = 4'd2; req1_op = 5'd1; req1_src1 = 16'h0020; req1_src2 = 16'h0021;
    alu_calc_res = 32'd0; alu_done = 1'b0; rsp_ready = 1'b0;

    // Reset with both requesters valid: nothing may be granted
    cyc(); cyc();
    #1;
    chk_reset_outputs("reset");

    // Lone requester 0, ADD 3+4, ALU done on first EXEC cycle
    req1_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("a_req0_ready", 32'(req0_ready), 32'd1);
    chk("a_req1_ready", 32'(req1_ready), 32'd0);
    cyc();
    req0_valid = 1'b0;
    alu_done = 1'b1; alu_calc_res = 32'h7;
    #1;
    chk("a_alu_start", 32'(alu_start), 32'd1);
    chk("a_alu_src1", 32'(alu_src1), 32'h3);
    chk("a_alu_src2", 32'(alu_src2), 32'h4);
    chk("a_alu_dtype", 32'(alu_dtype), 32'd1);
    chk("a_alu_operator", 32'(alu_operator), 32'd0);
    chk("a_rsp_valid_exec", 32'(rsp_valid), 32'd0);
    cyc();
    alu_done = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("a_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("a_rsp_id", 32'(rsp_id), 32'd0);
    chk("a_rsp_data", rsp_data, 32'h7);
    chk("a_rsp_err", 32'(rsp_err), 32'd0);
    chk("a_alu_start_resp", 32'(alu_start), 32'd0);
    cyc();
    #1;
    chk("a_rsp_valid_idle", 32'(rsp_valid), 32'd0);

    // Re-reset so last_grant is back to 1, then both valid continuously
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_src1 = 16'h0010;
    alu_done = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      alu_calc_res = 32'hA000 + 32'(k);
      #1;
      chk("b_req0_ready", 32'(req0_ready), 32'((k % 2) == 0));
      chk("b_req1_ready", 32'(req1_ready), 32'((k % 2) == 1));
      cyc();
      #1;
      chk("b_alu_start", 32'(alu_start), 32'd1);
      chk("b_alu_src1", 32'(alu_src1), ((k % 2) == 0) ? 32'h10 : 32'h20);
      chk("b_exec_ready", 32'(req0_ready | req1_ready), 32'd0);
      cyc();
      #1;
      chk("b_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("b_rsp_id", 32'(rsp_id), 32'(k % 2));
      chk("b_rsp_data", rsp_data, 32'hA000 + 32'(k));
      chk("b_resp_ready", 32'(req0_ready | req1_ready), 32'd0);
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; alu_done = 1'b0;
    cyc();

    // Illegal operator from requester 1 goes straight to RESP
    req1_valid = 1'b1; req1_op = 5'b10000;
    #1;
    chk("c_req1_ready", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;
    #1;
    chk("c_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("c_alu_start", 32'(alu_start), 32'd0);
    chk("c_rsp_err", 32'(rsp_err), 32'd1);
    chk("c_rsp_data", rsp_data, 32'd0);
    chk("c_rsp_id", 32'(rsp_id), 32'd1);
    cyc();

    // op == OP_MAX is legal; ALU never answers -> timeout after 15 EXEC cycles
    req0_valid = 1'b1; req0_op = 5'b00100;
    rsp_ready = 1'b0;
    #1;
    chk("d_req0_ready", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    start_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (!alu_start) break;
      start_cnt++;
      cyc();
    end
    #1;
    chk("d_exec_cycles", 32'(start_cnt), 32'd15);
    chk("d_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("d_rsp_err", 32'(rsp_err), 32'd2);
    chk("d_rsp_data", rsp_data, 32'd0);
    chk("d_rsp_id", 32'(rsp_id), 32'd0);

    // Backpressure: response held for 5 cycles while requester 1 waits
    req1_valid = 1'b1; req1_op = 5'd1; req1_src1 = 16'h0055;
    alu_done = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("e_hold_valid", 32'(rsp_valid), 32'd1);
      chk("e_hold_err", 32'(rsp_err), 32'd2);
      chk("e_hold_id", 32'(rsp_id), 32'd0);
      chk("e_hold_ready", 32'(req1_ready), 32'd0);
      cyc();
    end
    alu_done = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("e_handshake_ready", 32'(req1_ready), 32'd0);
    cyc();
    rsp_ready = 1'b0;
    #1;
    chk("e_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("e_next_grant", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;

    // alu_done arriving on the 15th EXEC cycle beats the timeout
    for (int n = 0; n < 14; n++) cyc();
    alu_done = 1'b1; alu_calc_res = 32'hDEADBEEF;
    #1;
    chk("f_alu_start_15", 32'(alu_start), 32'd1);
    chk("f_alu_src1", 32'(alu_src1), 32'h55);
    cyc();
    alu_done = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("f_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("f_rsp_err", 32'(rsp_err), 32'd0);
    chk("f_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("f_rsp_id", 32'(rsp_id), 32'd1);
    cyc();
    rsp_ready = 1'b0;

    // Reset in the middle of EXEC discards the command
    req0_valid = 1'b1; req0_op = 5'd2;
    cyc();
    req0_valid = 1'b0;
    #1;
    chk("g_alu_start", 32'(alu_start), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk_reset_outputs("g_after_rst");
    alu_done = 1'b1; rsp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      #1;
      chk("g_no_rsp", 32'(rsp_valid), 32'd0);
      chk("g_no_start", 32'(alu_start), 32'd0);
    end
    alu_done = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("g_tie_req0", 32'(req0_ready), 32'd1);
    chk("g_tie_req1", 32'(req1_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 15, is the number of EXEC cycles without alu_done before a timeout is declared (legal range 1-255).
REQ-002 Parameter: OP_MAX, default 5'b00100, is the highest legal operator code; codes above it are illegal.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 has a command.
REQ-006 req0_ready  output  1  requester 0 command accepted this cycle.
REQ-007 req0_dtype / req0_op / req0_src1 / req0_src2  input  4/5/16/16  requester 0 command fields.
REQ-008 req1_valid, req1_ready, req1_dtype, req1_op, req1_src1, req1_src2: same as REQ-005..007 for requester 1.
REQ-009 alu_dtype / alu_operator / alu_src1 / alu_src2  output  4/5/16/16  registered operands to ALU.
REQ-010 alu_start  output  1  drives ALU parser_done; high only in EXEC.
REQ-011 alu_calc_res  input  32  ALU result.
REQ-012 alu_done  input  1  ALU completion.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumer accepts.
REQ-015 rsp_id  output  1  requester index of response.
REQ-016 rsp_data  output  32  captured result.
REQ-017 rsp_err  output  2  00 ok, 01 illegal operator, 10 timeout.

Function
REQ-018 FSM states IDLE, EXEC, RESP; one command in flight at a time.
REQ-019 IDLE: if any reqN_valid, grant one, assert that reqN_ready combinationally for that cycle only, capture fields and id at the edge.
REQ-020 Arbitration round-robin: on simultaneous valid, grant the requester not granted last; last_grant resets to 1 (so requester 0 wins first tie).
REQ-021 Single valid requester is granted regardless of last_grant; last_grant updates on every grant.
REQ-022 reqN_ready is 0 in EXEC and RESP and for the non-granted requester.
REQ-023 Illegal operator (op > OP_MAX) at grant: skip EXEC, go to RESP with rsp_data=0, rsp_err=01; alu_start never asserted.
REQ-024 Legal op: IDLE -> EXEC; alu_start=1 each EXEC cycle; alu_* outputs hold captured fields throughout EXEC.
REQ-025 EXEC: alu_done=1 sampled at edge -> capture alu_calc_res into rsp_data, rsp_err=00, go RESP.
REQ-026 EXEC wait counter (8-bit) clears on entry, increments each EXEC cycle with alu_done=0; reaching MAX_WAIT -> rsp_data=0, rsp_err=10, go RESP.
REQ-027 alu_done and timeout in the same cycle: alu_done wins (rsp_err=00).
REQ-028 Minimum latency: grant at edge T, EXEC cycle T..T+1, rsp_valid high from T+2 (2 cycles grant-to-response).
REQ-029 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_err stable until rsp_valid&&rsp_ready at an edge, then IDLE.
REQ-030 No new grant in the RESP cycle where handshake completes; next grant earliest the following cycle.
REQ-031 alu_done outside EXEC is ignored.

Reset
REQ-032 rst=1 at an edge, from any state, including mid-EXEC or RESP: state=IDLE, counter=0, last_grant=1, in-flight command discarded with no response.
REQ-033 Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=00, alu_start=0, alu_dtype=0, alu_operator=0, alu_src1=0, alu_src2=0, req0_ready=0, req1_ready=0.
REQ-034 While rst=1, reqN_ready stays 0 regardless of reqN_valid.

Verification
REQ-035 req0 ADD src1=16'h0003 src2=16'h0004, alu_done with start -> rsp_valid at T+2, rsp_id=0, rsp_data=32'h7, rsp_err=00.
REQ-036 req0 and req1 both valid continuously after reset -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-037 req1 op=5'b10000 -> no alu_start, rsp_err=01, rsp_data=0, rsp_id=1.
REQ-038 alu_done held 0 -> rsp_err=10 after exactly 15 EXEC cycles; alu_done rising on 15th cycle -> rsp_err=00.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp fields stable, req ready 0; then handshake -> IDLE.
REQ-040 rst asserted mid-EXEC -> next cycle all outputs at REQ-033 values, no response for the discarded command.
